// File: rtl/pattern_checker.sv
// pattern_checker: watches an 8-bit ping-pong bus and checks that each
// tick-sampled value is the bitwise complement of the previous sample.
// Reports lock, a sticky error flag and a saturating error count.
module pattern_checker #(
    parameter int unsigned W      = 8,
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [W-1:0]     din,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [W-1:0]     last
);

    // Wide enough to hold LOCK_N itself.
    localparam int unsigned GW = $clog2(LOCK_N + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [GW-1:0]    LOCK_VAL = GW'(LOCK_N);

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     prev_q, prev_d;
    logic [W-1:0]     last_q, last_d;
    logic [GW-1:0]    good_cnt_q, good_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             good;
    logic             err_hit;
    logic [GW-1:0]    good_cnt_inc;
    logic [CNT_W-1:0] cnt_base;

    assign good         = (din == ~prev_q);
    assign good_cnt_inc = good_cnt_q + GW'(1);

    // Next-state for the lock FSM and sample registers; only a tick moves them.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        last_d     = last_q;
        good_cnt_d = good_cnt_q;
        err_hit    = 1'b0;
        if (tick) begin
            prev_d = din;
            last_d = din;
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = '0;
                end
                ST_ACQUIRE: begin
                    if (good) begin
                        if (good_cnt_inc == LOCK_VAL) begin
                            state_d    = ST_LOCKED;
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_cnt_inc;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!good) begin
                        err_hit    = 1'b1;
                        state_d    = ST_ACQUIRE;
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    // Error flag/counter next-state; a mismatch on the same edge as clr wins.
    always_comb begin
        cnt_base  = clr ? '0 : err_cnt_q;
        err_d     = clr ? 1'b0 : err_q;
        err_cnt_d = cnt_base;
        if (err_hit) begin
            err_d     = 1'b1;
            err_cnt_d = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            prev_q     <= '0;
            last_q     <= '0;
            good_cnt_q <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            last_q     <= last_d;
            good_cnt_q <= good_cnt_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign locked  = (state_q == ST_LOCKED);
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign last    = last_q;

endmodule

// File: tb/tb_pattern_checker.sv
// Directed bench for pattern_checker with hand-computed expectations.
module tb_pattern_checker;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [7:0] din;
    logic       clr;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic [7:0] last;

    int vectors;
    int miscompares;

    pattern_checker #(
        .W      (8),
        .LOCK_N (4),
        .CNT_W  (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .din     (din),
        .clr     (clr),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt),
        .last    (last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One sample: drive at negedge, the rising edge captures, outputs read at next negedge.
    task automatic tick_once(input logic [7:0] d, input logic c);
        @(negedge clk);
        tick = 1'b1;
        din  = d;
        clr  = c;
        @(negedge clk);
        tick = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic l, input logic e,
                           input logic [7:0] c, input logic [7:0] la);
        chk({tag, ".locked"}, 32'(locked), 32'(l));
        chk({tag, ".err"}, 32'(err), 32'(e));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(c));
        chk({tag, ".last"}, 32'(last), 32'(la));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst  = 1'b1;
        tick = 1'b0;
        din  = 8'h00;
        clr  = 1'b0;

        // Reset state
        #3 rst = 1'b0;
        #1 chk_all("reset", 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // Lock from reset
        tick_once(8'h55, 1'b0);
        tick_once(8'hAA, 1'b0);
        tick_once(8'h55, 1'b0);
        tick_once(8'hAA, 1'b0);
        chk("lock.pre", 32'(locked), 32'd0);
        tick_once(8'h55, 1'b0);
        chk_all("lock", 1'b1, 1'b0, 8'h00, 8'h55);

        // Single error then relock
        tick_once(8'h55, 1'b0);
        chk_all("err1", 1'b0, 1'b1, 8'h01, 8'h55);
        tick_once(8'hAA, 1'b0);
        tick_once(8'h55, 1'b0);
        tick_once(8'hAA, 1'b0);
        chk("relock.pre", 32'(locked), 32'd0);
        tick_once(8'h55, 1'b0);
        chk_all("relock", 1'b1, 1'b1, 8'h01, 8'h55);

        // Enable gating: din toggles with tick low
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            din = 8'($urandom);
            @(posedge clk);
            #1 chk("gate", {locked, err, err_cnt, last}, {1'b1, 1'b1, 8'h01, 8'h55});
        end
        // Prev must still be 0x55: 0xAA is good, 0x55 would be bad
        tick_once(8'hAA, 1'b0);
        chk_all("gate.after", 1'b1, 1'b1, 8'h01, 8'hAA);

        // Async reset between edges while locked with err set
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_all("areset", 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // Acquire noise from IDLE; 0xFF after prev=0 would count as good if not IDLE
        tick_once(8'hFF, 1'b0);
        tick_once(8'hFF, 1'b0);
        chk("idle.nolock", 32'(locked), 32'd0);
        tick_once(8'h55, 1'b0);
        tick_once(8'hAA, 1'b0);
        tick_once(8'hAA, 1'b0);
        tick_once(8'h55, 1'b0);
        tick_once(8'hAA, 1'b0);
        tick_once(8'h55, 1'b0);
        chk("noise.pre", 32'(locked), 32'd0);
        tick_once(8'hAA, 1'b0);
        chk_all("noise.lock", 1'b1, 1'b0, 8'h00, 8'hAA);

        // Saturation: 300 mismatches with relock between each
        for (int i = 0; i < 300; i++) begin
            tick_once(8'hAA, 1'b0);
            if (i == 9) chk("sat.cnt10", 32'(err_cnt), 32'd10);
            tick_once(8'h55, 1'b0);
            tick_once(8'hAA, 1'b0);
            tick_once(8'h55, 1'b0);
            tick_once(8'hAA, 1'b0);
        end
        chk_all("sat", 1'b1, 1'b1, 8'hFF, 8'hAA);

        // clr alone, no tick
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk_all("clr", 1'b1, 1'b0, 8'h00, 8'hAA);

        // Saturated count then clr with a mismatch on the same edge
        tick_once(8'hAA, 1'b0);
        chk_all("err.after.clr", 1'b0, 1'b1, 8'h01, 8'hAA);
        tick_once(8'h55, 1'b0);
        tick_once(8'hAA, 1'b0);
        tick_once(8'h55, 1'b0);
        tick_once(8'hAA, 1'b0);
        chk("relock2", 32'(locked), 32'd1);
        tick_once(8'hAA, 1'b1);
        chk_all("clr+err", 1'b0, 1'b1, 8'h01, 8'hAA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_checker.md
Name: pattern_checker

Overview:
- Downstream consumer of the ping-pong register pair's 8-bit output bus.
- Samples the bus once per prescaler tick and checks that each sample is the bitwise complement of the previous one (e.g. 0x55 -> 0xAA -> 0x55).
- Reports lock, a sticky error flag and a saturating error count, for on-board self-test of the register chain.
- Runs on the system clock; the prescaler tick is used as a clock enable, not as a clock.

Parameters:
W, 8, data bus width in bits
LOCK_N, 4, consecutive good complement transitions required to declare lock (1..255)
CNT_W, 8, width of error counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset; 0 clears all state immediately
tick  input  1  sample enable, one clk cycle wide per prescaler period
din  input  W  data bus from register pair
clr  input  1  synchronous clear of err and err_cnt
locked  output  1  1 while in LOCKED state
err  output  1  sticky: set on any mismatch while LOCKED
err_cnt  output  CNT_W  number of mismatches while LOCKED, saturating at all-ones
last  output  W  most recent sampled din

Behaviour:
- Reset (rst=0, async, no clock needed):
  - state=IDLE, prev=0, good_cnt=0.
  - locked=0, err=0, err_cnt=0, last=0.
- Release of rst is taken synchronously. The first edge after release with tick=1 is a normal sample.
- All state updates only on clk rising edges where tick=1, except clr.
- tick high for consecutive cycles: every such cycle is a separate sample.
- tick=0: din ignored, all state held.
- Outputs are registered and reflect a sample after the same clk edge that captured it (latency 1 clk from tick).
- Every sample loads prev<=din and last<=din. "Good" means din == ~prev (all W bits).
- IDLE:
  - On a sample: capture prev, good_cnt=0, go to ACQUIRE.
  - No comparison is made.
- ACQUIRE:
  - Good sample: good_cnt+1. If the new value equals LOCK_N, go to LOCKED, set locked=1, good_cnt=0.
  - Bad sample: good_cnt=0, stay in ACQUIRE.
  - Bad samples here never touch err or err_cnt.
- LOCKED:
  - Good sample: stay in LOCKED.
  - Bad sample: err=1; err_cnt+1 unless already all-ones (no wrap); locked=0; good_cnt=0; go to ACQUIRE.
  - The bad sample becomes the new prev.
- clr:
  - Any clk edge with clr=1 clears err and err_cnt; tick not required.
  - If clr and a LOCKED mismatch occur on the same edge, the error wins: err=1, err_cnt=1.
  - clr does not affect state, locked, prev or last.
- good_cnt width is ceil(log2(LOCK_N+1)) bits.
- LOCK_N=1: a single good transition after the first sample locks.

Test Plan:
- Lock from reset (LOCK_N=4): release rst; ticks with din=0x55,0xAA,0x55,0xAA,0x55 -> locked rises after the 5th tick edge; err=0, err_cnt=0, last=0x55.
- Single error: from lock, tick din=0x55 after 0x55 -> locked=0, err=1, err_cnt=1. Then 0xAA,0x55,0xAA,0x55 -> locked=1 again, err still 1, err_cnt=1.
- Acquire noise: from IDLE, ticks 0x55,0xAA,0xAA,0x55,0xAA,0x55,0xAA -> no lock until the 4th consecutive good transition (the last tick); err_cnt stays 0.
- Saturation and clr priority:
  - Force 300 LOCKED mismatches, relocking between each -> err_cnt=0xFF.
  - Assert clr alone -> err=0, err_cnt=0.
  - Assert clr together with a LOCKED mismatch -> err=1, err_cnt=1.
- Enable gating: tick=0 while din toggles randomly for 50 cycles in LOCKED -> no output change.
- Async reset mid-lock: drive rst=0 between clk edges while locked, err=1 -> all outputs 0 before the next edge; state returns to IDLE.
